// File: rtl/mux_scan_ctrl_pkg.sv
// mux_scan_pkg: shared widths, FSM state encoding, sample payload and the
// round-robin search helper for the mux channel scanner.
package mux_scan_pkg;

  localparam int unsigned NCH   = 8;
  localparam int unsigned SELW  = 3;
  localparam int unsigned W     = 4;
  localparam int unsigned DWELL = 4;
  localparam int unsigned CNTW  = $clog2(DWELL) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_e;

  // Captured sample handed downstream.
  typedef struct packed {
    logic [W-1:0]    data;
    logic [SELW-1:0] ch;
  } smp_t;

  // Result of a round-robin search.
  typedef struct packed {
    logic [SELW-1:0] idx;
    logic            wrap;
  } rr_res_t;

  // First set bit of mask strictly after cur, modulo NCH. wrap is set when
  // the found index is not above cur (covers the single-bit case, where the
  // search comes all the way round to cur itself).
  function automatic rr_res_t next_enabled(input logic [NCH-1:0]  mask,
                                           input logic [SELW-1:0] cur);
    rr_res_t         r;
    logic            found;
    logic [SELW-1:0] k;
    r.idx  = cur;
    r.wrap = 1'b1;
    found  = 1'b0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      k = cur + SELW'(i);
      if (!found && mask[k]) begin
        r.idx  = k;
        r.wrap = (k <= cur);
        found  = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: control, mux-side and sample-handshake signals of the
// channel scanner.
//   master : upstream controller / mux / downstream sink (drives start, stop,
//            continuous, ch_mask, mux_data, smp_ready)
//   slave  : the scanner (drives mux_sel, smp_*, busy, done)
interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic            start;
  logic            stop;
  logic            continuous;
  logic [NCH-1:0]  ch_mask;
  logic [SELW-1:0] mux_sel;
  logic [W-1:0]    mux_data;
  logic [W-1:0]    smp_data;
  logic [SELW-1:0] smp_ch;
  logic            smp_valid;
  logic            smp_ready;
  logic            busy;
  logic            done;

  modport master (
    output start, stop, continuous, ch_mask, mux_data, smp_ready,
    input  mux_sel, smp_data, smp_ch, smp_valid, busy, done
  );

  modport slave (
    input  start, stop, continuous, ch_mask, mux_data, smp_ready,
    output mux_sel, smp_data, smp_ch, smp_valid, busy, done
  );

endinterface

// File: rtl/mux_scan_ctrl_rr_next_sel.sv
// rr_next_sel: combinational round-robin search over an enable mask.
//   mask_i     : channel enables
//   cur_i      : current channel; search starts strictly after it
//   nxt_c_o    : next enabled channel
//   wrap_c_o   : search wrapped (next <= cur)
module rr_next_sel
  import mux_scan_pkg::*;
(
  input  logic [NCH-1:0]  mask_i,
  input  logic [SELW-1:0] cur_i,
  output logic [SELW-1:0] nxt_c_o,
  output logic            wrap_c_o
);

  rr_res_t res;

  always_comb begin
    res      = next_enabled(mask_i, cur_i);
    nxt_c_o  = res.idx;
    wrap_c_o = res.wrap;
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: time-multiplexed scanner in front of an 8:1 x 4-bit mux.
// Drives the select, waits DWELL settle cycles, captures the nibble and
// offers it downstream on a valid/ready handshake; round-robin over a
// sampled channel mask, single sweep or continuous.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of mux_scan_ctrl_if
module mux_scan_ctrl (
  input  logic             clk,
  input  logic             rst_n,
  mux_scan_ctrl_if.slave   bus
);
  import mux_scan_pkg::*;

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_SETTLE = ST_SETTLE;
  localparam logic [1:0] S_HOLD   = ST_HOLD;

  logic [1:0]      state_q,     state_d;
  logic [SELW-1:0] mux_sel_q,   mux_sel_d;
  smp_t            smp_q,       smp_d;
  logic            smp_valid_q, smp_valid_d;
  logic            done_q,      done_d;
  logic            busy_q,      busy_d;
  logic [NCH-1:0]  mask_q,      mask_d;
  logic [CNTW-1:0] cnt_q,       cnt_d;
  logic            cont_q,      cont_d;
  logic            stop_pend_q, stop_pend_d;

  logic [SELW-1:0] first_sel;
  logic            first_wrap_unused;
  logic [SELW-1:0] adv_sel;
  logic            adv_wrap;

  // Lowest enabled channel of the incoming mask (search after NCH-1).
  rr_next_sel u_first (
    .mask_i   (bus.ch_mask),
    .cur_i    (SELW'(NCH - 1)),
    .nxt_c_o  (first_sel),
    .wrap_c_o (first_wrap_unused)
  );

  // Next enabled channel after the one currently selected.
  rr_next_sel u_adv (
    .mask_i   (mask_q),
    .cur_i    (mux_sel_q),
    .nxt_c_o  (adv_sel),
    .wrap_c_o (adv_wrap)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mux_sel_q   <= '0;
      smp_q       <= '0;
      smp_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      mask_q      <= '0;
      cnt_q       <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mux_sel_q   <= mux_sel_d;
      smp_q       <= smp_d;
      smp_valid_q <= smp_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    mux_sel_d   = mux_sel_q;
    smp_d       = smp_q;
    smp_valid_d = smp_valid_q;
    done_d      = 1'b0;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q;

    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (bus.start) begin
          if (bus.ch_mask != '0) begin
            mask_d    = bus.ch_mask;
            cont_d    = bus.continuous;
            mux_sel_d = first_sel;
            cnt_d     = CNTW'(DWELL - 1);
            state_d   = S_SETTLE;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_SETTLE: begin
        // Abort wins over capture: no sample once stop is seen here.
        if (bus.stop) begin
          done_d      = 1'b1;
          stop_pend_d = 1'b0;
          state_d     = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNTW'(1);
        end else begin
          smp_d.data  = bus.mux_data;
          smp_d.ch    = mux_sel_q;
          smp_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end

      S_HOLD: begin
        // A stop here is remembered; the sample is still delivered.
        if (bus.stop) begin
          stop_pend_d = 1'b1;
        end
        if (smp_valid_q && bus.smp_ready) begin
          smp_valid_d = 1'b0;
          if ((adv_wrap && !cont_q) || stop_pend_q || bus.stop) begin
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            mux_sel_d = adv_sel;
            cnt_d     = CNTW'(DWELL - 1);
            state_d   = S_SETTLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.mux_sel   = mux_sel_q;
  assign bus.smp_data  = smp_q.data;
  assign bus.smp_ch    = smp_q.ch;
  assign bus.smp_valid = smp_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: the stimulus pushes hand-computed
// samples, a monitor pops and compares on every handshake.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux_scan_ctrl_if bus_if ();

  mux_scan_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Mux model: channel contents 0..7.
  logic [3:0] chan [8] = '{4'd12, 4'd15, 4'd1, 4'd3, 4'd5, 4'd2, 4'd11, 4'd14};
  assign bus_if.mux_data = chan[bus_if.mux_sel];

  typedef struct {
    int data;
    int ch;
  } exp_t;

  exp_t exp_q[$];
  int   hs_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  int   done_cnt = 0;
  int   st_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input int c);
    exp_t e;
    e.data = d;
    e.ch   = c;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus_if.smp_valid && bus_if.smp_ready) begin
          hs_cnt++;
          hs_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sample: got ch=%0d data=%0d expected no sample",
                     bus_if.smp_ch, bus_if.smp_data);
          end else begin
            e = exp_q.pop_front();
            chk("sample_data", int'(bus_if.smp_data), e.data);
            chk("sample_ch", int'(bus_if.smp_ch), e.ch);
          end
        end
        if (bus_if.done) begin
          done_cnt++;
          chk("busy_low_with_done", int'(bus_if.busy), 0);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] mask, input logic cont);
    bus_if.ch_mask    = mask;
    bus_if.continuous = cont;
    bus_if.start      = 1'b1;
    st_cyc = cyc + 1;
    tick();
    bus_if.start = 1'b0;
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n = 0;
    while (hs_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (hs_cnt < target) chk("handshake_timeout", hs_cnt, target);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk("done_count", done_cnt, target);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!bus_if.smp_valid && n < budget) begin
      tick();
      n++;
    end
    chk("valid_timeout", int'(bus_if.smp_valid), 1);
  endtask

  task automatic stimulus();
    int hb;
    int d0;
    int h0;

    bus_if.start      = 1'b0;
    bus_if.stop       = 1'b0;
    bus_if.continuous = 1'b0;
    bus_if.ch_mask    = '0;
    bus_if.smp_ready  = 1'b1;
    repeat (3) tick();

    // Reset state.
    chk("rst_mux_sel", int'(bus_if.mux_sel), 0);
    chk("rst_smp_valid", int'(bus_if.smp_valid), 0);
    chk("rst_smp_data", int'(bus_if.smp_data), 0);
    chk("rst_done", int'(bus_if.done), 0);
    chk("rst_busy", int'(bus_if.busy), 0);
    rst_n = 1'b1;
    tick();

    // Full single sweep, ready held high.
    hb = hs_cyc.size();
    d0 = done_cnt;
    push_exp(12, 0); push_exp(15, 1); push_exp(1, 2); push_exp(3, 3);
    push_exp(5, 4);  push_exp(2, 5);  push_exp(11, 6); push_exp(14, 7);
    do_start(8'hFF, 1'b0);
    chk("busy_in_scan", int'(bus_if.busy), 1);
    wait_done(d0 + 1, 80);
    chk("sweep_drained", exp_q.size(), 0);
    if (hs_cyc.size() >= hb + 8) begin
      chk("first_latency", hs_cyc[hb] - st_cyc, 4);
      for (int i = 1; i < 8; i++) chk("sample_period", hs_cyc[hb + i] - hs_cyc[hb + i - 1], 5);
    end else begin
      chk("sweep_sample_count", hs_cyc.size() - hb, 8);
    end
    repeat (5) tick();
    chk("sweep_single_done", done_cnt, d0 + 1);

    // Continuous scan of channels 3,5,7, stop while settling.
    h0 = hs_cnt;
    d0 = done_cnt;
    push_exp(3, 3); push_exp(2, 5); push_exp(14, 7); push_exp(3, 3);
    do_start(8'b1010_1000, 1'b1);
    wait_hs(h0 + 4, 60);
    bus_if.stop = 1'b1;
    tick();
    bus_if.stop = 1'b0;
    chk("stop_settle_idle", int'(bus_if.busy), 0);
    repeat (20) tick();
    chk("stop_settle_done", done_cnt, d0 + 1);
    chk("stop_settle_no_more", hs_cnt, h0 + 4);

    // Backpressure on channel 2.
    h0 = hs_cnt;
    d0 = done_cnt;
    push_exp(12, 0); push_exp(15, 1); push_exp(1, 2); push_exp(3, 3);
    push_exp(5, 4);  push_exp(2, 5);  push_exp(11, 6); push_exp(14, 7);
    do_start(8'hFF, 1'b0);
    wait_hs(h0 + 2, 30);
    bus_if.smp_ready = 1'b0;
    wait_valid(10);
    for (int i = 0; i < 10; i++) begin
      chk("hold_stable", int'({bus_if.smp_valid, bus_if.smp_data, bus_if.smp_ch, bus_if.mux_sel}),
          int'({1'b1, 4'd1, 3'd2, 3'd2}));
      tick();
    end
    chk("hold_no_advance", hs_cnt, h0 + 2);
    bus_if.smp_ready = 1'b1;
    wait_done(d0 + 1, 60);
    chk("bp_drained", exp_q.size(), 0);

    // Empty mask: done only.
    h0 = hs_cnt;
    d0 = done_cnt;
    do_start(8'h00, 1'b0);
    chk("empty_busy", int'(bus_if.busy), 0);
    chk("empty_done_now", int'(bus_if.done), 1);
    repeat (4) tick();
    chk("empty_done_once", done_cnt, d0 + 1);
    chk("empty_no_sample", hs_cnt, h0);

    // Single enabled channel 6.
    d0 = done_cnt;
    push_exp(11, 6);
    do_start(8'h40, 1'b0);
    wait_done(d0 + 1, 20);
    chk("single_drained", exp_q.size(), 0);

    // Stop while holding: sample still delivered.
    h0 = hs_cnt;
    d0 = done_cnt;
    bus_if.smp_ready = 1'b0;
    push_exp(12, 0);
    do_start(8'hFF, 1'b1);
    wait_valid(10);
    bus_if.stop = 1'b1;
    tick();
    bus_if.stop = 1'b0;
    repeat (3) tick();
    chk("stop_hold_valid_kept", int'(bus_if.smp_valid), 1);
    chk("stop_hold_busy", int'(bus_if.busy), 1);
    bus_if.smp_ready = 1'b1;
    wait_done(d0 + 1, 10);
    repeat (15) tick();
    chk("stop_hold_one_sample", hs_cnt, h0 + 1);

    // Asynchronous reset while settling, then rescan.
    do_start(8'b0000_1100, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_mux_sel", int'(bus_if.mux_sel), 0);
    chk("arst_smp_data", int'(bus_if.smp_data), 0);
    chk("arst_busy", int'(bus_if.busy), 0);
    chk("arst_valid", int'(bus_if.smp_valid), 0);
    tick();
    rst_n = 1'b1;
    tick();
    d0 = done_cnt;
    push_exp(1, 2); push_exp(3, 3);
    do_start(8'b0000_1100, 1'b0);
    wait_done(d0 + 1, 30);
    chk("rescan_drained", exp_q.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
